line_memory_arbiter: RTL
========================

// Module: line_memory_arbiter
// PURPOSE
//  Shares one 128-bit line-wide backing memory between the instruction-cache refill path
//  and the data-cache refill/writeback path. Sits between the fetch-stage cache and
//  memory-stage cache (requesters) and the line memory (single outstanding access).
//  Sequences each access with a req/ack handshake and forwards line-aligned addresses.
// PARAMETERS
//  ADDR_W  32   byte-address width on all address ports
//  LINE_W  128  line width in bits (4 x 32-bit words)
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  i_req      in   1       I-cache line-read request; held high until i_ack
//  i_addr     in   ADDR_W  I-cache miss address; stable while i_req high
//  i_ack      out  1       one-cycle pulse: i_line valid
//  i_line     out  LINE_W  returned instruction line
//  d_req      in   1       D-cache request; held high until d_ack
//  d_we       in   1       1 = line write (writeback), 0 = line read
//  d_addr     in   ADDR_W  D-cache address; stable while d_req high
//  d_wdata    in   LINE_W  writeback line; stable while d_req high
//  d_ack      out  1       one-cycle pulse: access done (d_line valid on reads)
//  d_line     out  LINE_W  returned data line (reads)
//  mem_req    out  1       memory access in progress
//  mem_we     out  1       memory write enable, valid while mem_req
//  mem_addr   out  ADDR_W  line-aligned address (bits [3:0] forced to 0)
//  mem_wdata  out  LINE_W  write line, valid while mem_req & mem_we
//  mem_ready  in   1       one-cycle completion from memory; ignored unless state BUSY
//  mem_rdata  in   LINE_W  read line, valid with mem_ready
// BEHAVIOUR
//  - Reset: state IDLE; i_ack=d_ack=mem_req=mem_we=0; mem_addr, mem_wdata, i_line,
//    d_line = 0; last_grant = I. Reset mid-access abandons it: mem_req drops
//    asynchronously; no ack is issued; the requester re-requests after reset.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: at edge with any req high, latch winner, addr (&~15), we, wdata; mem_req=1; ->BUSY.
//    BUSY: outputs stable; on edge with mem_ready=1: capture mem_rdata into winner's line
//          register, pulse winner's ack, mem_req=0, mem_we=0; ->DONE.
//    DONE: ack high exactly this cycle; requests ignored; next edge ->IDLE (ack=0).
//  - Latency: req sampled at edge E0; mem_req high from E0; mem_ready sampled at E1>E0;
//    ack high E1..E1+1. Zero-wait memory: ack 2 cycles after req; back-to-back throughput
//    1 access / 3 cycles.
//  - i_line/d_line hold last captured value until next capture of same requester.
//  - Write accesses (d_we=1) also capture mem_rdata; contents are don't-care.
//  - i_req is read-only; no i_we. mem_we=0 on every I grant.
//  - mem_ready outside BUSY: ignored, no state change.
//  - Requester dropping req before ack: illegal; access still completes and acks.
//  - Single outstanding access; never two acks in one cycle; i_ack and d_ack exclusive.
// CONFIGURATION
//  ROUND_ROBIN_EN defined: simultaneous i_req & d_req in IDLE grants the requester
//    not in last_grant; last_grant updates on every grant. Single requester always wins.
//  ROUND_ROBIN_EN undefined: fixed priority, D beats I on ties; last_grant unused
//    (reset-only). I starvation under continuous d_req is accepted.
// TESTING
//  1 i_req=1, i_addr=0x0000_0014, ready 3 cycles later, rdata=0xA..A ->
//    mem_addr=0x10, mem_we=0, i_ack 1 cycle, i_line=0xA..A, d_ack never high.
//  2 d_req=1, d_we=1, d_addr=0x2C, d_wdata=0x1234.. -> mem_we=1, mem_addr=0x20,
//    mem_wdata=0x1234.., d_ack 1 cycle after mem_ready.
//  3 i_req and d_req rise same edge, zero-wait memory -> D acked first, I acked
//    3 cycles later (both configs, since last_grant resets to I).
//  4 ROUND_ROBIN_EN, both held for 4 accesses -> ack order D,I,D,I; without macro
//    and d_req re-raised after each ack -> D,D,D,D, i_ack never.
//  5 reset_n low during BUSY -> mem_req=0 immediately, no ack; after release,
//    re-request completes normally.
//  6 mem_ready pulse in IDLE and in DONE -> no ack, no state change, lines unchanged.

Source files
------------

// File: rtl/line_memory_arbiter.sv
// line_memory_arbiter: shares one line-wide backing memory between the I-cache refill
// path and the D-cache refill/writeback path, one outstanding access at a time.
// Optional build macro: ROUND_ROBIN_EN (alternate grants on simultaneous requests);
// when undefined, D wins ties over I.
module line_memory_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_line,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_line,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_d_q, grant_d_d;   // 1: current access belongs to D
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_line_q, i_line_d;
  logic [LINE_W-1:0] d_line_q, d_line_d;
  logic              pick_d;

`ifdef ROUND_ROBIN_EN
  logic              last_d_q, last_d_d;     // 1: most recent grant went to D

  // Round robin: on a tie, grant whichever requester did not win last time
  always_comb begin
    pick_d = d_req && (!i_req || !last_d_q);
  end
`else
  // Fixed priority: D wins whenever it is requesting
  always_comb begin
    pick_d = d_req;
  end
`endif

  // Next-state and registered-output computation for the access sequencer
  always_comb begin
    state_d     = state_q;
    grant_d_d   = grant_d_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_line_d    = i_line_q;
    d_line_d    = d_line_q;
`ifdef ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          grant_d_d  = pick_d;
          mem_req_d  = 1'b1;
          mem_we_d   = pick_d && d_we;
          mem_addr_d = (pick_d ? d_addr : i_addr) & LINE_MASK;
          if (pick_d) begin
            mem_wdata_d = d_wdata;
          end
`ifdef ROUND_ROBIN_EN
          last_d_d   = pick_d;
`endif
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          if (grant_d_q) begin
            d_line_d = mem_rdata;
            d_ack_d  = 1'b1;
          end else begin
            i_line_d = mem_rdata;
            i_ack_d  = 1'b1;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      grant_d_q   <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_line_q    <= '0;
      d_line_q    <= '0;
`ifdef ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_d_q   <= grant_d_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_line_q    <= i_line_d;
      d_line_q    <= d_line_d;
`ifdef ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_line    = i_line_q;
  assign d_line    = d_line_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
